// File: rtl/uart_tx_fifo_if.sv
// Host-side push port and line/status outputs of the buffered 8N1 UART transmitter.
// i_data_byte is accepted on a rising edge where i_data_valid && o_ready; when o_ready is low the push is dropped.
interface uart_tx_fifo_if;
  logic       i_data_valid;
  logic [7:0] i_data_byte;
  logic       o_ready;
  logic       o_tx;
  logic       o_busy;
  logic       o_done;
  logic [1:0] dbg_state;

  modport master (
    output i_data_valid, i_data_byte,
    input  o_ready, o_tx, o_busy, o_done, dbg_state
  );

  modport slave (
    input  i_data_valid, i_data_byte,
    output o_ready, o_tx, o_busy, o_done, dbg_state
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames are sent LSB-first and
// back-to-back whenever the FIFO holds more data at the end of a stop bit.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clock,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [15:0]     LAST_CNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          ready;
  logic          empty;
  logic          push;
  logic          pop;

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_q, tx_d;

  assign ready = (count_q != FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = bus.i_data_valid & ready;

  assign bus.o_ready   = ready;
  assign bus.o_tx      = tx_q;
  assign bus.o_busy    = (state_q != S_IDLE);
  assign bus.o_done    = (state_q == S_STOP) && (cnt_q == LAST_CNT);
  assign bus.dbg_state = state_q;

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_data_byte;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      tx_byte_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_byte_q <= tx_byte_d;
      tx_q      <= tx_d;
    end
  end

  // tx_d is the line level for the cycle after this edge, so o_tx stays registered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    tx_byte_d = tx_byte_q;
    tx_d      = 1'b1;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop       = 1'b1;
          tx_byte_d = mem_q[rd_ptr_q];
          state_d   = S_START;
          tx_d      = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
          tx_d      = tx_byte_q[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
          tx_d  = 1'b0;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = tx_byte_q[bit_idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
          tx_d  = tx_byte_q[bit_idx_q];
        end
      end
      S_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (!empty) begin
            pop       = 1'b1;
            tx_byte_d = mem_q[rd_ptr_q];
            state_d   = S_START;
            tx_d      = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        bit_idx_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 8 clocks/bit with a 4-entry FIFO: frame shape,
// back-to-back framing, FIFO full behaviour, reset mid-frame and a multi-byte burst.
module tb_uart_tx_fifo;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_line;   // bit i is the i-th bit on the wire: start, d0..d7, stop
    logic       exp_ready;
  } push_vec_t;

  logic clock;
  logic reset;
  uart_tx_fifo_if bus ();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  push_vec_t full_vecs  [6];
  push_vec_t burst_vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: call at a falling edge; returns at the falling edge after the push edge
  task automatic push(input push_vec_t v, input string name);
    check({name, "_ready"}, 32'(bus.o_ready), 32'(v.exp_ready));
    bus.i_data_valid = 1'b1;
    bus.i_data_byte  = v.data;
    @(posedge clock);
    @(negedge clock);
    bus.i_data_valid = 1'b0;
    if (v.exp_ready) exp_q.push_back(v.exp_line);
  endtask

  // Call at the falling edge just before frame cycle 1; returns at the falling edge of cycle 80.
  task automatic watch_frame(input string name, output logic rdy_first);
    logic [9:0] exp_line;
    logic [9:0] got;
    int         glitch;
    int         done_cnt;
    int         done_at;
    int         busy_cnt;
    exp_line  = 10'h3FF;
    got       = '0;
    glitch    = 0;
    done_cnt  = 0;
    done_at   = 0;
    busy_cnt  = 0;
    rdy_first = 1'b0;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_queue: got empty expected queue entry", name);
    end else begin
      exp_line = exp_q.pop_front();
    end
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clock);
      if (k == 1) rdy_first = bus.o_ready;
      if (bus.o_tx !== exp_line[(k-1)/CPB]) glitch++;
      if ((k-1) % CPB == CPB/2) got[(k-1)/CPB] = bus.o_tx;
      if (bus.o_done === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      if (bus.o_busy === 1'b1) busy_cnt++;
    end
    check({name, "_line"},     32'(got),      32'(exp_line));
    check({name, "_timing"},   32'(glitch),   32'd0);
    check({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({name, "_done_at"},  32'(done_at),  32'(FRAME));
    check({name, "_busy_cnt"}, 32'(busy_cnt), 32'(FRAME));
  endtask

  task automatic check_idle(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) bad++;
    end
    check({name, "_idle"},  32'(bad), 32'd0);
    check({name, "_ready"}, 32'(bus.o_ready), 32'd1);
  endtask

  initial begin
    logic rdy;
    int   done_seen;

    full_vecs[0] = '{8'h11, 10'h222, 1'b1};
    full_vecs[1] = '{8'h12, 10'h224, 1'b1};
    full_vecs[2] = '{8'h13, 10'h226, 1'b1};
    full_vecs[3] = '{8'h14, 10'h228, 1'b1};
    full_vecs[4] = '{8'h15, 10'h22A, 1'b1};
    full_vecs[5] = '{8'h16, 10'h22C, 1'b0};

    burst_vecs[0] = '{8'h00, 10'h200, 1'b1};
    burst_vecs[1] = '{8'h55, 10'h2AA, 1'b1};
    burst_vecs[2] = '{8'hAA, 10'h354, 1'b1};
    burst_vecs[3] = '{8'hFF, 10'h3FE, 1'b1};
    burst_vecs[4] = '{8'h3C, 10'h278, 1'b1};

    bus.i_data_valid = 1'b0;
    bus.i_data_byte  = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clock);

    check("rst_tx",    32'(bus.o_tx),      32'd1);
    check("rst_ready", 32'(bus.o_ready),   32'd1);
    check("rst_busy",  32'(bus.o_busy),    32'd0);
    check("rst_done",  32'(bus.o_done),    32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // single byte: line must still be idle between accept edge and pop edge
    push('{8'hA5, 10'h34A, 1'b1}, "a5");
    check("a5_pre_tx",   32'(bus.o_tx),   32'd1);
    check("a5_pre_busy", 32'(bus.o_busy), 32'd0);
    watch_frame("a5", rdy);
    @(negedge clock);
    check("a5_post_tx",   32'(bus.o_tx),   32'd1);
    check("a5_post_busy", 32'(bus.o_busy), 32'd0);
    repeat (3) @(negedge clock);

    // back-to-back: second start bit right after first stop bit
    push('{8'h00, 10'h200, 1'b1}, "b2b0");
    fork
      push('{8'hFF, 10'h3FE, 1'b1}, "b2b1");
      watch_frame("b2b0", rdy);
    join
    watch_frame("b2b1", rdy);
    check_idle("b2b", 10);

    // FIFO full: 0x16 must be dropped
    push(full_vecs[0], "full0");
    fork
      for (int i = 1; i < 6; i++) push(full_vecs[i], $sformatf("full%0d", i));
      watch_frame("full_f0", rdy);
    join
    check("full_ready_low", 32'(bus.o_ready), 32'd0);
    watch_frame("full_f1", rdy);
    check("full_ready_rise", 32'(rdy), 32'd1);
    for (int i = 2; i < 5; i++) watch_frame($sformatf("full_f%0d", i), rdy);
    check("full_queue_drained", 32'(exp_q.size()), 32'd0);
    check_idle("full", 40);

    // reset during bit 3 of 0x5A with two bytes queued
    push('{8'h5A, 10'h2B4, 1'b1}, "rst5a");
    done_seen = 0;
    fork
      begin
        push('{8'h01, 10'h202, 1'b1}, "rstq0");
        push('{8'h02, 10'h204, 1'b1}, "rstq1");
      end
      for (int k = 1; k <= 36; k++) begin
        @(negedge clock);
        if (bus.o_done === 1'b1) done_seen++;
      end
    join
    check("mid_busy_before", 32'(bus.o_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_tx",    32'(bus.o_tx),      32'd1);
    check("mid_busy",  32'(bus.o_busy),    32'd0);
    check("mid_state", 32'(bus.dbg_state), 32'd0);
    check("mid_ready", 32'(bus.o_ready),   32'd1);
    check("mid_done",  32'(done_seen),     32'd0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_idle("after_rst", 200);

    // burst of five bytes, fills the FIFO exactly
    push(burst_vecs[0], "burst0");
    fork
      for (int i = 1; i < 5; i++) push(burst_vecs[i], $sformatf("burst%0d", i));
      watch_frame("burst_f0", rdy);
    join
    for (int i = 1; i < 5; i++) watch_frame($sformatf("burst_f%0d", i), rdy);
    check_idle("burst", 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
